sobel_stream: RTL

Streaming, parametrised 3×3 Sobel edge detector: it takes one raster-order pixel per accepted beat and emits one gradient magnitude |Gx|+|Gy| for every fully interior window. It generalises the fixed 512-wide, file-driven Sobel model into a synthesisable block with configurable pixel width and image size, valid/ready flow control, frame-position tracking and end-of-frame marking. It sits between the pixel source (image reader / DMA) and the edge-map writer in the vision pipeline.

---
 rtl/sobel_stream_if.sv | 50 +++++
 rtl/sobel_stream.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/sobel_stream_if.sv
// ---------------------------------------------------------------------------
// sobel_stream_if
//   Handshake bundle for the streaming Sobel edge detector: pixel input
//   channel plus gradient-magnitude output channel.
//
//   Parameters
//     PIX_W : input pixel width
//     MAG_W : output magnitude width (PIX_W+3, or PIX_W when saturating)
//
//   Signals
//     in_valid / in_ready / in_pixel     : pixel stream into the detector
//     out_valid / out_ready / out_mag /
//     out_last                           : magnitude stream out of it
//
//   Modports
//     slave  : the detector's view (consumes pixels, produces magnitudes)
//     master : the environment's view (pixel source + magnitude sink)
// ---------------------------------------------------------------------------
interface sobel_stream_if #(
    parameter int PIX_W = 8,
    parameter int MAG_W = 11
);
    logic             in_valid;
    logic             in_ready;
    logic [PIX_W-1:0] in_pixel;
    logic             out_valid;
    logic             out_ready;
    logic [MAG_W-1:0] out_mag;
    logic             out_last;

    modport slave (
        input  in_valid,
        input  in_pixel,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_mag,
        output out_last
    );

    modport master (
        output in_valid,
        output in_pixel,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_mag,
        input  out_last
    );
endinterface

// File: rtl/sobel_stream.sv
// ---------------------------------------------------------------------------
// sobel_stream
//   Streaming 3x3 Sobel edge detector. Takes one raster-order pixel per
//   accepted beat and emits |Gx|+|Gy| for every fully interior window
//   (row >= 2, col >= 2). Borders produce no output; no padding.
//
//   Optional feature macro: SOBEL_SAT_EN
//     defined   : MAG_W = PIX_W, magnitude saturates at 2^PIX_W-1
//     undefined : MAG_W = PIX_W+3, full-precision magnitude
//
//   Ports
//     clk  : single clock, rising edge
//     rst  : asynchronous active-high reset
//     bus  : sobel_stream_if.slave (pixel in, magnitude out, out_last)
//
//   Parameters
//     PIX_W : pixel width (unsigned)
//     IMG_W : image width  (>= 3)
//     IMG_H : image height (>= 3)
// ---------------------------------------------------------------------------
module sobel_stream #(
    parameter int PIX_W = 8,
    parameter int IMG_W = 512,
    parameter int IMG_H = 512
) (
    input  logic        clk,
    input  logic        rst,
    sobel_stream_if.slave bus
);

`ifdef SOBEL_SAT_EN
    localparam int MAG_W = PIX_W;
`else
    localparam int MAG_W = PIX_W + 3;
`endif
    localparam int SW = PIX_W + 3;
    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    // Line buffers: r_lb1 holds row r-1, r_lb2 holds row r-2 (by column).
    logic [PIX_W-1:0] r_lb1 [IMG_W];
    logic [PIX_W-1:0] r_lb2 [IMG_W];

    // Two-deep column history per window row: d1 = col c-1, d2 = col c-2.
    logic [PIX_W-1:0] r_top_d1, r_top_d2;
    logic [PIX_W-1:0] r_mid_d1, r_mid_d2;
    logic [PIX_W-1:0] r_bot_d1, r_bot_d2;

    logic [CW-1:0]    r_col;
    logic [RW-1:0]    r_row;

    logic             r_out_valid;
    logic [MAG_W-1:0] r_out_mag;
    logic             r_out_last;

    logic             w_in_ready;
    logic             w_accept;
    logic             w_emit;
    logic             w_last;
    logic [PIX_W-1:0] w_top_r, w_mid_r, w_bot_r;
    logic signed [SW-1:0] w_gx, w_gy;
    logic [SW-1:0]    w_abs_gx, w_abs_gy;
    logic [SW-1:0]    w_sum;
    logic [MAG_W-1:0] w_mag;

    function automatic logic signed [SW-1:0] ext(input logic [PIX_W-1:0] p);
        return $signed({3'b000, p});
    endfunction

    // Single output register: ready whenever it is empty or being drained.
    assign w_in_ready = !r_out_valid || bus.out_ready;
    assign w_accept   = bus.in_valid && w_in_ready;

    // Right column of the window comes straight from the buffers and input.
    assign w_top_r = r_lb2[r_col];
    assign w_mid_r = r_lb1[r_col];
    assign w_bot_r = bus.in_pixel;

    assign w_gx = (ext(w_top_r) - ext(r_top_d2))
                + ((ext(w_mid_r) - ext(r_mid_d2)) + (ext(w_mid_r) - ext(r_mid_d2)))
                + (ext(w_bot_r) - ext(r_bot_d2));

    assign w_gy = (ext(r_top_d2) - ext(r_bot_d2))
                + ((ext(r_top_d1) - ext(r_bot_d1)) + (ext(r_top_d1) - ext(r_bot_d1)))
                + (ext(w_top_r) - ext(w_bot_r));

    // |G| <= 4*(2^PIX_W-1), so negation and the sum both fit in SW bits.
    assign w_abs_gx = w_gx[SW-1] ? SW'(-w_gx) : SW'(w_gx);
    assign w_abs_gy = w_gy[SW-1] ? SW'(-w_gy) : SW'(w_gy);
    assign w_sum    = w_abs_gx + w_abs_gy;

`ifdef SOBEL_SAT_EN
    assign w_mag = (w_sum > SW'((2 ** PIX_W) - 1)) ? {MAG_W{1'b1}} : w_sum[MAG_W-1:0];
`else
    assign w_mag = w_sum;
`endif

    // Rows 0/1 and columns 0/1 never emit, which also hides the
    // uninitialised line-buffer contents and the row-wrap history.
    assign w_emit = (r_row >= RW'(2)) && (r_col >= CW'(2));
    assign w_last = (r_row == RW'(IMG_H - 1)) && (r_col == CW'(IMG_W - 1));

    // Frame position counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_accept) begin
            if (r_col == CW'(IMG_W - 1)) begin
                r_col <= '0;
                if (r_row == RW'(IMG_H - 1)) begin
                    r_row <= '0;
                end else begin
                    r_row <= r_row + 1'b1;
                end
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    // Window storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_lb2[r_col] <= r_lb1[r_col];
            r_lb1[r_col] <= bus.in_pixel;
            r_top_d1     <= w_top_r;
            r_top_d2     <= r_top_d1;
            r_mid_d1     <= w_mid_r;
            r_mid_d2     <= r_mid_d1;
            r_bot_d1     <= w_bot_r;
            r_bot_d2     <= r_bot_d1;
        end
    end

    // Output register: reloads or empties whenever it may change hands,
    // otherwise holds its contents through a downstream stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_mag   <= '0;
            r_out_last  <= 1'b0;
        end else if (w_in_ready) begin
            r_out_valid <= w_accept && w_emit;
            if (w_accept && w_emit) begin
                r_out_mag  <= w_mag;
                r_out_last <= w_last;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_mag   = r_out_mag;
    assign bus.out_last  = r_out_last;

endmodule
